// File: rtl/line_pkg.sv
// Shared formats, FSM states and iteration counts for the line normaliser.
package line_pkg;

    localparam int FRAC_BITS   = 16;
    localparam int SQRT_CYCLES = 32;
    localparam int DIV_CYCLES  = 17;

    typedef logic signed [31:0] fixed_t;

    typedef enum logic [2:0] {
        IDLE,
        SQUARE,
        SQRT,
        DIV_X,
        DIV_Y,
        DONE
    } state_t;

    // Magnitude of a Q16.16 value; -2^31 maps to 0x80000000, which still fits unsigned.
    function automatic logic [31:0] abs_fixed(input fixed_t v);
        fixed_t neg_v;
        neg_v = -v;
        return v[31] ? neg_v : v;
    endfunction

    // Re-apply the displacement sign to an unsigned quotient (truncation toward zero).
    function automatic fixed_t apply_sign(input logic neg, input logic [16:0] q);
        fixed_t m;
        m = {15'b0, q};
        return neg ? -m : m;
    endfunction

endpackage

// File: rtl/q16_divider.sv
// Unsigned restoring divider producing a 17-bit quotient, one bit per cycle.
// The caller guarantees dividend < divisor * 2^17, so the upper dividend bits
// can seed the partial remainder directly and only 17 bits need developing.
module q16_divider
    import line_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [47:0] dividend,
    input  logic [31:0] divisor,
    output logic [16:0] quotient,
    output logic        done
);

    logic [31:0] r_rem;
    logic [16:0] r_low;
    logic [15:0] r_quo;
    logic [31:0] r_div;
    logic [4:0]  r_cnt;
    logic        r_busy;

    logic [32:0] w_shift;
    logic        w_bit;
    logic [31:0] w_rem_next;

    // One restoring step: bring down the next dividend bit and trial-subtract.
    always_comb begin
        w_shift    = {r_rem, r_low[16]};
        w_bit      = (w_shift >= {1'b0, r_div});
        w_rem_next = w_bit ? 32'(w_shift - {1'b0, r_div}) : w_shift[31:0];
    end

    // Final quotient is presented during the last step so the caller can capture
    // it on the same edge that may restart the divider.
    assign quotient = {r_quo, w_bit};
    assign done     = r_busy && (r_cnt == 5'(DIV_CYCLES - 1));

    // Divider iteration registers; start always wins and reloads the operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_low  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_rem  <= {1'b0, dividend[47:17]};
            r_low  <= dividend[16:0];
            r_quo  <= '0;
            r_div  <= divisor;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem  <= w_rem_next;
            r_low  <= {r_low[15:0], 1'b0};
            r_quo  <= {r_quo[14:0], w_bit};
            r_cnt  <= r_cnt + 5'd1;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/line_normalizer.sv
// Turns a segment (origin + displacement) into origin, unit direction and length.
// Sequence: square-sum, 32-step integer square root, then the shared divider
// run for x and for y.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; in_ready is high only in IDLE and out_valid only in DONE, and a result
// stays frozen in DONE until out_ready is seen.
module line_normalizer
    import line_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x0_in,
    input  logic [31:0] y0_in,
    input  logic [31:0] dx_in,
    input  logic [31:0] dy_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] x0,
    output logic [31:0] y0,
    output logic [31:0] xn,
    output logic [31:0] yn,
    output logic [31:0] mag
);

    state_t      r_state;
    state_t      w_next;

    fixed_t      r_x0_lat;
    fixed_t      r_y0_lat;
    fixed_t      r_dx;
    fixed_t      r_dy;

    logic [63:0] r_rad;
    logic [33:0] r_rem;
    logic [31:0] r_root;
    logic [5:0]  r_cnt;
    fixed_t      r_xq;

    logic [31:0] r_o_x0;
    logic [31:0] r_o_y0;
    logic [31:0] r_o_xn;
    logic [31:0] r_o_yn;
    logic [31:0] r_o_mag;

    logic [63:0] w_dx64;
    logic [63:0] w_dy64;
    logic [63:0] w_sumsq;

    logic [35:0] w_rem_sh;
    logic [35:0] w_trial;
    logic        w_ge;
    logic [33:0] w_rem_next;
    logic [31:0] w_root_next;

    logic        w_accept;
    logic        w_load_sqrt;
    logic        w_sqrt_step;
    logic        w_zero_done;
    logic        w_div_start;
    logic        w_div_sel_y;
    logic        w_cap_x;
    logic        w_finish;

    logic [31:0] w_abs_sel;
    logic [47:0] w_dividend;
    logic [31:0] w_divisor;
    logic [16:0] w_div_q;
    logic        w_div_done;

    // Sum of squares: the low 64 bits of the sign-extended products are exact
    // because each square is non-negative and the sum fits for legal inputs.
    always_comb begin
        w_dx64  = {{32{r_dx[31]}}, r_dx};
        w_dy64  = {{32{r_dy[31]}}, r_dy};
        w_sumsq = (w_dx64 * w_dx64) + (w_dy64 * w_dy64);
    end

    // One digit-by-digit square-root step: shift in two radicand bits, try 4*root+1.
    always_comb begin
        w_rem_sh    = {r_rem, r_rad[63:62]};
        w_trial     = {2'b00, r_root, 2'b01};
        w_ge        = (w_rem_sh >= w_trial);
        w_rem_next  = w_ge ? 34'(w_rem_sh - w_trial) : w_rem_sh[33:0];
        w_root_next = {r_root[30:0], w_ge};
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state and datapath control strobes.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_load_sqrt = 1'b0;
        w_sqrt_step = 1'b0;
        w_zero_done = 1'b0;
        w_div_start = 1'b0;
        w_div_sel_y = 1'b0;
        w_cap_x     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = SQUARE;
                end
            end
            SQUARE: begin
                if (w_sumsq == 64'd0) begin
                    w_zero_done = 1'b1;
                    w_next      = DONE;
                end else begin
                    w_load_sqrt = 1'b1;
                    w_next      = SQRT;
                end
            end
            SQRT: begin
                w_sqrt_step = 1'b1;
                if (r_cnt == 6'(SQRT_CYCLES - 1)) begin
                    w_div_start = 1'b1;
                    w_next      = DIV_X;
                end
            end
            DIV_X: begin
                if (w_div_done) begin
                    w_cap_x     = 1'b1;
                    w_div_start = 1'b1;
                    w_div_sel_y = 1'b1;
                    w_next      = DIV_Y;
                end
            end
            DIV_Y: begin
                if (w_div_done) begin
                    w_finish = 1'b1;
                    w_next   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Divider operands: during the last root step the root is not yet registered,
    // so the combinational next root is used as the divisor.
    always_comb begin
        w_abs_sel  = w_div_sel_y ? abs_fixed(r_dy) : abs_fixed(r_dx);
        w_dividend = {w_abs_sel, 16'h0000};
        w_divisor  = (r_state == SQRT) ? w_root_next : r_root;
    end

    q16_divider u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_div_start),
        .dividend (w_dividend),
        .divisor  (w_divisor),
        .quotient (w_div_q),
        .done     (w_div_done)
    );

    // Input latch, square-root iteration and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x0_lat <= '0;
            r_y0_lat <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_rad    <= '0;
            r_rem    <= '0;
            r_root   <= '0;
            r_cnt    <= '0;
            r_xq     <= '0;
            r_o_x0   <= '0;
            r_o_y0   <= '0;
            r_o_xn   <= '0;
            r_o_yn   <= '0;
            r_o_mag  <= '0;
        end else begin
            if (w_accept) begin
                r_x0_lat <= x0_in;
                r_y0_lat <= y0_in;
                r_dx     <= dx_in;
                r_dy     <= dy_in;
            end
            if (w_load_sqrt) begin
                r_rad  <= w_sumsq;
                r_rem  <= '0;
                r_root <= '0;
                r_cnt  <= '0;
            end
            if (w_sqrt_step) begin
                r_rad  <= {r_rad[61:0], 2'b00};
                r_rem  <= w_rem_next;
                r_root <= w_root_next;
                r_cnt  <= r_cnt + 6'd1;
            end
            if (w_cap_x) begin
                r_xq <= apply_sign(r_dx[31], w_div_q);
            end
            if (w_finish) begin
                r_o_x0  <= r_x0_lat;
                r_o_y0  <= r_y0_lat;
                r_o_xn  <= r_xq;
                r_o_yn  <= apply_sign(r_dy[31], w_div_q);
                r_o_mag <= r_root;
            end
            if (w_zero_done) begin
                r_o_x0  <= r_x0_lat;
                r_o_y0  <= r_y0_lat;
                r_o_xn  <= '0;
                r_o_yn  <= '0;
                r_o_mag <= '0;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign x0        = r_o_x0;
    assign y0        = r_o_y0;
    assign xn        = r_o_xn;
    assign yn        = r_o_yn;
    assign mag       = r_o_mag;

endmodule

// File: tb/tb_line_normalizer.sv
// Directed bench for line_normalizer: driver pushes expected results into a
// queue at the accepting edge, a monitor pops and compares on each output transfer.
module tb_line_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x0_in;
  logic [31:0] y0_in;
  logic [31:0] dx_in;
  logic [31:0] dy_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] x0;
  logic [31:0] y0;
  logic [31:0] xn;
  logic [31:0] yn;
  logic [31:0] mag;

  int checks = 0;
  int failures = 0;
  logic [159:0] exp_q[$];
  logic [159:0] mon_e;

  line_normalizer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x0_in     (x0_in),
    .y0_in     (y0_in),
    .dx_in     (dx_in),
    .dy_in     (dy_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x0        (x0),
    .y0        (y0),
    .xn        (xn),
    .yn        (yn),
    .mag       (mag)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check32({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check32({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    check32({tag, "_x0"}, x0, 32'd0);
    check32({tag, "_y0"}, y0, 32'd0);
    check32({tag, "_xn"}, xn, 32'd0);
    check32({tag, "_yn"}, yn, 32'd0);
    check32({tag, "_mag"}, mag, 32'd0);
  endtask

  // monitor: one pop per output transfer
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_unexpected actual=result required=none");
      end else begin
        mon_e = exp_q.pop_front();
        check32("mon_x0", x0, mon_e[159:128]);
        check32("mon_y0", y0, mon_e[127:96]);
        check32("mon_xn", xn, mon_e[95:64]);
        check32("mon_yn", yn, mon_e[63:32]);
        check32("mon_mag", mag, mon_e[31:0]);
      end
    end
  end

  // Present a segment and wait for the accepting edge (in_ready is high in IDLE).
  task automatic accept_seg(input logic [31:0] ax0, input logic [31:0] ay0,
                            input logic [31:0] adx, input logic [31:0] ady);
    @(negedge clk);
    x0_in    = ax0;
    y0_in    = ay0;
    dx_in    = adx;
    dy_in    = ady;
    in_valid = 1'b1;
    @(posedge clk);
  endtask

  // driver: full segment with latency, optional busy-time noise and output stall
  task automatic run_seg(input logic [31:0] ax0, input logic [31:0] ay0,
                         input logic [31:0] adx, input logic [31:0] ady,
                         input logic [31:0] exn, input logic [31:0] eyn,
                         input logic [31:0] emag, input int exp_lat,
                         input int stall, input bit noise);
    int lat;
    accept_seg(ax0, ay0, adx, ady);
    exp_q.push_back({ax0, ay0, exn, eyn, emag});
    #1;
    if (noise) begin
      x0_in = $urandom;
      y0_in = $urandom;
      dx_in = $urandom_range(32'h3FFFFFFF, 0);
      dy_in = $urandom_range(32'h3FFFFFFF, 0);
    end else begin
      in_valid = 1'b0;
    end
    check32("busy_in_ready", {31'b0, in_ready}, 32'd0);
    // latency counted with the accepting edge as edge 1
    lat = 1;
    while (lat < 300) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 10) in_valid = 1'b0;
      if (out_valid) break;
    end
    in_valid = 1'b0;
    check32("latency", lat, exp_lat);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check32("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check32("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check32("stall_xn", xn, exn);
      check32("stall_yn", yn, eyn);
      check32("stall_mag", mag, emag);
    end
    if (stall > 0) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check32("post_in_ready", {31'b0, in_ready}, 32'd1);
    check32("post_out_valid", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x0_in     = '0;
    y0_in     = '0;
    dx_in     = '0;
    dy_in     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // 3-4-5
    run_seg(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000,
            32'h0000_9999, 32'h0000_CCCC, 32'h0005_0000, 68, 0, 1'b0);
    // -3,4 with in_valid and garbage held during busy
    run_seg(32'hFFFF_8000, 32'h0000_4000, 32'hFFFD_0000, 32'h0004_0000,
            32'hFFFF_6667, 32'h0000_CCCC, 32'h0005_0000, 68, 0, 1'b1);
    // 0,-2
    run_seg(32'h1234_5678, 32'h8765_4321, 32'h0000_0000, 32'hFFFE_0000,
            32'h0000_0000, 32'hFFFF_0000, 32'h0002_0000, 68, 0, 1'b0);
    // zero vector
    run_seg(32'h0000_0007, 32'hFFFF_FFF9, 32'h0000_0000, 32'h0000_0000,
            32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2, 0, 1'b0);
    // 1,1: mag = floor(sqrt(2)*2^16), xn = yn = floor(2^32 / 92681)
    run_seg(32'h0000_0000, 32'h0000_0000, 32'h0001_0000, 32'h0001_0000,
            32'h0000_B505, 32'h0000_B505, 32'h0001_6A09, 68, 0, 1'b0);
    // 3-4-5 with a 20-cycle downstream stall
    run_seg(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000,
            32'h0000_9999, 32'h0000_CCCC, 32'h0005_0000, 68, 20, 1'b0);

    // reset 30 cycles into a segment aborts it
    accept_seg(32'h0005_0000, 32'h0006_0000, 32'h0003_0000, 32'h0004_0000);
    #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    run_seg(32'h0009_0000, 32'h000A_0000, 32'h0004_0000, 32'hFFFD_0000,
            32'h0000_CCCC, 32'hFFFF_6667, 32'h0005_0000, 68, 0, 1'b0);

    repeat (5) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drained actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
